// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed restoring divider.
// Holds the controller state encoding and the two's-complement magnitude helper.
package div_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int ABS_MAXW  = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    HOLD = 3'd4
  } state_e;

  // Magnitude of a w-bit two's-complement value carried in a wide container.
  // The most negative value maps onto its own bit pattern, i.e. unsigned 2^(w-1).
  function automatic logic [ABS_MAXW-1:0] abs_w(input logic [ABS_MAXW-1:0] v,
                                                input int unsigned        w);
    logic [ABS_MAXW-1:0] mask;
    logic                neg;
    mask  = (ABS_MAXW'(1) << w) - ABS_MAXW'(1);
    neg   = |(v & (ABS_MAXW'(1) << (w - 1)));
    abs_w = neg ? ((~v + ABS_MAXW'(1)) & mask) : (v & mask);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operator-facing bundle of the divider: switches, load/run levels and the
// remainder/quotient registers with their status lamps.
interface seq_divider_if #(
  parameter int WIDTH = div_pkg::WIDTH_DEF
);
  logic             Load;
  logic             Run;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic             Ovf;

  modport master (
    output Load, Run, SW,
    input  Aval, Bval, Busy, Done, DivZero, Ovf
  );

  modport slave (
    input  Load, Run, SW,
    output Aval, Bval, Busy, Done, DivZero, Ovf
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = div_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sh;

  // The partial remainder is always below the divisor magnitude, so its top
  // bit is zero and the (WIDTH+1)-bit trial behaves as an unsigned subtract.
  always_comb begin
    rem_sh  = {rem_in[WIDTH-2:0], bit_in};
    trial   = {rem_in, bit_in} - {1'b0, dvsr};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : rem_sh;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: Bval holds the dividend and then the
// quotient, Aval the remainder; one quotient bit resolves per clock.
//
//   state | meaning
//   IDLE  | wait for Load (capture dividend) or Run (start op)
//   PREP  | screen divide-by-zero / MIN by -1, take magnitudes
//   ITER  | WIDTH restoring steps, one quotient bit each
//   FIX   | restore signs of quotient and remainder
//   HOLD  | result shown with Done; leave once Run is released
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  seq_divider_if.slave  dif
);

  localparam int               CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (a_q),
    .bit_in  (b_q[WIDTH-1]),
    .dvsr    (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;

    case (state_q)
      IDLE: begin
        if (dif.Load) begin
          b_d   = dif.SW;
          a_d   = '0;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
        end else if (dif.Run) begin
          dvsr_d    = dif.SW;
          neg_dvd_d = b_q[WIDTH-1];
          neg_dvs_d = dif.SW[WIDTH-1];
          state_d   = PREP;
        end
      end

      PREP: begin
        if (dvsr_q == '0) begin
          b_d     = ONES;
          a_d     = b_q;
          dz_d    = 1'b1;
          state_d = HOLD;
        end else if ((b_q == MIN_VAL) && (dvsr_q == ONES)) begin
          b_d     = MIN_VAL;
          a_d     = '0;
          ovf_d   = 1'b1;
          state_d = HOLD;
        end else begin
          b_d     = WIDTH'(abs_w(ABS_MAXW'(b_q), WIDTH));
          dvsr_d  = WIDTH'(abs_w(ABS_MAXW'(dvsr_q), WIDTH));
          a_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end

      ITER: begin
        a_d   = step_rem;
        b_d   = {b_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        b_d     = (neg_dvd_q ^ neg_dvs_q) ? -b_q : b_q;
        a_d     = neg_dvd_q ? -a_q : a_q;
        state_d = HOLD;
      end

      HOLD: begin
        if (!dif.Run) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dif.Aval    = a_q;
  assign dif.Bval    = b_q;
  assign dif.Busy    = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign dif.Done    = (state_q == HOLD);
  assign dif.DivZero = dz_q;
  assign dif.Ovf     = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: stimulus queues hand-computed results and a
// negedge monitor checks them, plus latency, whenever Done rises.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic [7:0] a;
    logic       dz;
    logic       ovf;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_rises;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .dif   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: latency = negedges spent Busy plus the edge that sampled Run.
  int   busy_cnt;
  logic prev_done;
  initial begin
    busy_cnt  = 0;
    prev_done = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (dif.Done === 1'b1 && prev_done !== 1'b1) begin
      done_rises++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_bval"},    dif.Bval,    e.b);
        chk({e.name, "_aval"},    dif.Aval,    e.a);
        chk({e.name, "_divzero"}, dif.DivZero, e.dz);
        chk({e.name, "_ovf"},     dif.Ovf,     e.ovf);
        chk({e.name, "_latency"}, busy_cnt + 1, e.lat);
      end
    end
    if (dif.Busy === 1'b1) busy_cnt++;
    else busy_cnt = 0;
    prev_done = dif.Done;
  end

  task automatic do_load(input logic [7:0] v);
    @(posedge clk);
    #1 dif.Load = 1'b1;
    dif.SW = v;
    @(posedge clk);
    #1 dif.Load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic lvl);
    int n;
    n = 0;
    while (dif.Done !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({nm, "_timeout"}, dif.Done, lvl);
  endtask

  task automatic run_op(input string nm, input logic ld, input logic [7:0] dvd,
                        input logic [7:0] dvs, input logic [7:0] eb,
                        input logic [7:0] ea, input logic edz, input logic eovf,
                        input int elat);
    exp_t e;
    if (ld) do_load(dvd);
    e = '{nm, eb, ea, edz, eovf, elat};
    sb.push_back(e);
    dif.SW  = dvs;
    dif.Run = 1'b1;
    wait_done(nm, 1'b1);
    dif.Run = 1'b0;
    wait_done({nm, "_release"}, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    done_rises = 0;
    rst        = 1'b1;
    dif.Load   = 1'b0;
    dif.Run    = 1'b0;
    dif.SW     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_aval",    dif.Aval,    0);
    chk("rst_bval",    dif.Bval,    0);
    chk("rst_busy",    dif.Busy,    0);
    chk("rst_done",    dif.Done,    0);
    chk("rst_divzero", dif.DivZero, 0);
    chk("rst_ovf",     dif.Ovf,     0);

    run_op("p100_d7",    1, 8'h64, 8'h07, 8'h0E, 8'h02, 0, 0, 11);
    run_op("m100_d7",    1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 0, 0, 11);
    run_op("p100_dm7",   1, 8'h64, 8'hF9, 8'hF2, 8'h02, 0, 0, 11);
    run_op("m7_d2",      1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0, 11);
    run_op("min_dm1",    1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, 2);
    run_op("min_d1",     1, 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, 11);
    run_op("min_dmin",   1, 8'h80, 8'h80, 8'h01, 8'h00, 0, 0, 11);
    run_op("p127_dmin",  1, 8'h7F, 8'h80, 8'h00, 8'h7F, 0, 0, 11);
    run_op("p42_d0",     1, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1, 0, 2);

    do_load(8'h2A);
    @(negedge clk);
    chk("load_clears_divzero", dif.DivZero, 0);
    chk("load_bval",           dif.Bval,    8'h2A);
    chk("load_aval",           dif.Aval,    8'h00);

    // Run held high for many cycles must yield a single division.
    begin
      exp_t e;
      int   r0;
      do_load(8'h64);
      e = '{"held_run", 8'h0E, 8'h02, 1'b0, 1'b0, 11};
      sb.push_back(e);
      r0 = done_rises;
      dif.SW  = 8'h07;
      dif.Run = 1'b1;
      repeat (40) @(negedge clk);
      chk("held_one_op",     done_rises - r0, 1);
      chk("held_done_stays", dif.Done, 1);
      chk("held_busy_low",   dif.Busy, 0);
      dif.Run = 1'b0;
      @(negedge clk);
      chk("held_back_idle",  dif.Done, 0);
    end
    run_op("chain_d3", 0, 8'h00, 8'h03, 8'h04, 8'h02, 0, 0, 11);

    // Reset in the middle of the iteration phase.
    do_load(8'h64);
    dif.SW  = 8'h07;
    dif.Run = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("midop_busy", dif.Busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dif.Run = 1'b0;
    @(negedge clk);
    chk("midrst_aval", dif.Aval, 0);
    chk("midrst_bval", dif.Bval, 0);
    chk("midrst_busy", dif.Busy, 0);
    chk("midrst_done", dif.Done, 0);
    run_op("after_rst", 1, 8'h64, 8'h07, 8'h0E, 8'h02, 0, 0, 11);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
